// File: rtl/piezo_sound_arbiter_pkg.sv
// Shared types and constants for the piezo tone arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package piezo_arb_pkg;

  localparam int NUM_REQ = 3;
  localparam int NOTE_W  = 4;

  // Requester indices, highest priority first.
  localparam int REQ_MISS = 0;
  localparam int REQ_ECHO = 1;
  localparam int REQ_PLAY = 2;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Keep only the lowest set bit, i.e. the highest-priority requester.
  function automatic logic [NUM_REQ-1:0] lowest_one(input logic [NUM_REQ-1:0] m);
    return m & (~m + NUM_REQ'(1));
  endfunction

endpackage

// File: rtl/piezo_sound_arbiter_tick_gen.sv
// Game-tick divider: free-running 0..TICK_DIV-1 counter with one-cycle tick.
// Latency: tick asserted combinationally in the cycle the count reaches TICK_DIV-1.
// Backpressure: none; clear restarts the count from 0 on the next cycle.
module tick_gen
  import piezo_arb_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  // Count cycles within a tick, wrapping on tick or restarting on clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/piezo_sound_arbiter.sv
// Fixed-priority arbiter sharing one piezo between miss, echo and playback tones.
// Latency: accept in cycle N drives piezo_out/grant from N+1; done/dropped are registered pulses.
// Backpressure: req_ready only for the top eligible requester; none during GAP, stop or reset.
module piezo_sound_arbiter
  import piezo_arb_pkg::*;
#(
  parameter int TICK_DIV  = 5_000_000,
  parameter int GAP_TICKS = 1,
  parameter int DUR_W     = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*NOTE_W-1:0]   req_note,
  input  logic [NUM_REQ*DUR_W-1:0]    req_dur,
  input  logic                        stop,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NOTE_W-1:0]           piezo_out,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy,
  output logic [NUM_REQ-1:0]          done,
  output logic [NUM_REQ-1:0]          dropped
);

  localparam int GW = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);

  state_e               state_q, state_d;
  logic [DUR_W-1:0]     rem_q, rem_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [NOTE_W-1:0]    piezo_d;
  logic [NUM_REQ-1:0]   grant_d, done_d, dropped_d;
  logic [NUM_REQ-1:0]   elig;
  logic [NOTE_W-1:0]    sel_note;
  logic [DUR_W-1:0]     sel_dur;
  logic                 tick, div_clear, finish, accept;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear),
    .tick  (tick)
  );

  assign busy   = (state_q != IDLE);
  // Last tick of the tone; completion beats any preemption landing in the same cycle.
  assign finish = (state_q == PLAY) && tick && (rem_q == DUR_W'(1));

  // Decide who may be accepted this cycle and pick the winner's payload.
  always_comb begin
    elig     = '0;
    sel_note = NOTE_REST;
    sel_dur  = '0;
    if (!stop) begin
      case (state_q)
        IDLE:    elig = req_valid;
        // Only requesters strictly above the owner (lower index) may preempt.
        PLAY:    if (!finish) elig = req_valid & (grant - NUM_REQ'(1));
        default: elig = '0;
      endcase
    end
    req_ready = reset ? lowest_one(elig) : '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_note = req_note[NOTE_W*i +: NOTE_W];
        sel_dur  = req_dur[DUR_W*i +: DUR_W];
      end
    end
  end

  // Next-state and next-output logic for the IDLE/PLAY/GAP sequencer.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    piezo_d   = piezo_out;
    grant_d   = grant;
    done_d    = '0;
    dropped_d = '0;
    div_clear = (state_q == IDLE);
    accept    = |req_ready;
    if (stop) begin
      state_d   = IDLE;
      piezo_d   = NOTE_REST;
      grant_d   = '0;
      div_clear = 1'b1;
    end else if (accept) begin
      dropped_d = (state_q == PLAY) ? grant : '0;
      state_d   = PLAY;
      piezo_d   = sel_note;
      grant_d   = req_ready;
      rem_d     = (sel_dur == '0) ? DUR_W'(1) : sel_dur;
      div_clear = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          if (finish) begin
            done_d    = grant;
            piezo_d   = NOTE_REST;
            grant_d   = '0;
            gap_d     = GW'(GAP_TICKS);
            state_d   = (GAP_TICKS == 0) ? IDLE : GAP;
            div_clear = 1'b1;
          end else if (tick) begin
            rem_d = rem_q - DUR_W'(1);
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_q == GW'(1)) begin
              state_d   = IDLE;
              div_clear = 1'b1;
            end else begin
              gap_d = gap_q - GW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Register sequencer state and all driven outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      gap_q     <= '0;
      piezo_out <= NOTE_REST;
      grant     <= '0;
      done      <= '0;
      dropped   <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      piezo_out <= piezo_d;
      grant     <= grant_d;
      done      <= done_d;
      dropped   <= dropped_d;
    end
  end

endmodule

// File: tb/tb_piezo_sound_arbiter.sv
// Scoreboard bench for piezo_sound_arbiter with a time-arithmetic reference model.
// Latency: expected events are stamped with the cycle they must appear in.
// Backpressure: requesters hold valid/payload until a valid&ready handshake.
module tb_piezo_sound_arbiter;

  localparam int TD = 4;
  localparam int GT = 1;
  localparam int DW = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stop = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [11:0] req_note = '0;
  logic [8:0]  req_dur = '0;
  logic [2:0]  req_ready, grant, done, dropped;
  logic [3:0]  piezo_out;
  logic        busy;

  piezo_sound_arbiter #(.TICK_DIV(TD), .GAP_TICKS(GT), .DUR_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_note  (req_note),
    .req_dur   (req_dur),
    .stop      (stop),
    .req_ready (req_ready),
    .piezo_out (piezo_out),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [2:0] g;
    logic [3:0] n;
    logic [2:0] d;
    logic [2:0] dr;
  } ev_t;

  ev_t exp_q[$];

  // Reference model: who owns the piezo, last cycle of the tone, first cycle a new accept is legal.
  int         own = -1;
  logic [3:0] m_note = '0;
  int         t_end = 0;
  int         quiet_until = 0;

  // Requester side: wanted requests, handshakes seen, stimulus controls.
  logic [2:0] w_vld = '0;
  logic [3:0] w_note [3];
  logic [2:0] w_dur [3];
  logic [2:0] acc_seen = '0;
  bit         rand_mode = 1'b0;
  bit         stop_next = 1'b0;
  int         rand_div = 10;

  task automatic post(input int i, input logic [3:0] n, input logic [2:0] d);
    if (!w_vld[i]) begin
      w_vld[i]  = 1'b1;
      w_note[i] = n;
      w_dur[i]  = d;
    end
  endtask

  task automatic model_cycle();
    logic [2:0] cand, exp_rdy, exp_g;
    logic [3:0] exp_n;
    logic       exp_b;
    int         k, d;
    ev_t        e;
    exp_g = (own >= 0) ? 3'(1 << own) : 3'b000;
    exp_n = (own >= 0) ? m_note : 4'd0;
    exp_b = (own >= 0) || (cyc < quiet_until);
    check("outputs", {24'd0, busy, grant, piezo_out}, {24'd0, exp_b, exp_g, exp_n});
    cand = '0;
    if (!stop) begin
      if (own >= 0) begin
        if (cyc < t_end)
          for (int i = 0; i < own; i++) if (req_valid[i]) cand[i] = 1'b1;
      end else if (cyc >= quiet_until) begin
        cand = req_valid;
      end
    end
    exp_rdy = '0;
    k = -1;
    for (int i = 2; i >= 0; i--) if (cand[i]) begin exp_rdy = 3'(1 << i); k = i; end
    check("req_ready", {29'd0, req_ready}, {29'd0, exp_rdy});
    acc_seen = req_valid & req_ready;
    if (stop) begin
      own = -1;
      quiet_until = cyc + 1;
    end else if (k >= 0) begin
      e.cyc = cyc + 1;
      e.g   = exp_rdy;
      e.n   = req_note[4*k +: 4];
      e.d   = '0;
      e.dr  = (own >= 0) ? 3'(1 << own) : 3'b000;
      exp_q.push_back(e);
      d = int'(req_dur[3*k +: 3]);
      if (d == 0) d = 1;
      own    = k;
      m_note = e.n;
      t_end  = cyc + d * TD;
    end else if (own >= 0 && cyc == t_end) begin
      e.cyc = cyc + 1;
      e.g   = '0;
      e.n   = '0;
      e.d   = 3'(1 << own);
      e.dr  = '0;
      exp_q.push_back(e);
      own = -1;
      quiet_until = cyc + 1 + GT * TD;
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      w_vld    = w_vld & ~acc_seen;
      acc_seen = '0;
      if (rand_mode) begin
        for (int i = 0; i < 3; i++)
          if ($urandom_range(0, rand_div - 1) == 0)
            post(i, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        stop = ($urandom_range(0, 49) == 0);
      end else begin
        stop = stop_next;
        stop_next = 1'b0;
      end
      req_valid = w_vld;
      for (int i = 0; i < 3; i++) begin
        req_note[4*i +: 4] = w_note[i];
        req_dur[3*i +: 3]  = w_dur[i];
      end
      @(negedge clk);
      model_cycle();
    end
  endtask

  // Monitor: any pulse or newly granted tone is an output event to be matched in order.
  logic [2:0] prev_grant = '0;
  ev_t        me;
  always @(negedge clk) begin
    if (!reset) begin
      prev_grant = '0;
    end else begin
      if (done != 0 || dropped != 0 || (grant != 0 && grant != prev_grant)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {16'(cyc), 3'd0, grant, piezo_out, done, dropped}, 32'd0);
        end else begin
          me = exp_q.pop_front();
          check("event", {16'(cyc), 3'd0, grant, piezo_out, done, dropped},
                {16'(me.cyc), 3'd0, me.g, me.n, me.d, me.dr});
        end
      end
      prev_grant = grant;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_piezo"}, {28'd0, piezo_out}, 32'd0);
    check({tag, "_grant"}, {29'd0, grant}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_pulses"}, {26'd0, done, dropped}, 32'd0);
    check({tag, "_ready"}, {29'd0, req_ready}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin w_note[i] = '0; w_dur[i] = '0; end
    // Reset with all requesters asserting: nothing may be accepted.
    req_valid = 3'b111;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    req_valid = '0;
    reset = 1'b1;

    // Playback note 5, dur 2: 8 cycles of tone, done, 4 gap cycles.
    post(2, 4'd5, 3'd2);
    run(20);
    // All three at once: miss, then echo, then playback.
    post(0, 4'd1, 3'd1);
    post(1, 4'd2, 3'd2);
    post(2, 4'd3, 3'd1);
    run(60);
    // Echo preempts a long playback tone.
    post(2, 4'd3, 3'd7);
    run(10);
    post(1, 4'd9, 3'd1);
    run(20);
    // Stop mid-tone while echo is requesting: stop wins, echo served next.
    post(2, 4'd4, 3'd5);
    run(6);
    stop_next = 1'b1;
    post(1, 4'd7, 3'd2);
    run(1);
    run(20);
    // Zero-duration rest, miss arriving during the gap waits for IDLE.
    post(2, 4'd0, 3'd0);
    run(6);
    post(0, 4'd8, 3'd1);
    run(20);

    // Randomized traffic, busy then sparser.
    rand_mode = 1'b1;
    rand_div = 10;
    run(1500);
    rand_div = 30;
    run(800);
    rand_mode = 1'b0;
    stop = 1'b0;

    // Reset in the middle of a tone.
    run(40);
    post(2, 4'd6, 3'd7);
    run(12);
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    own = -1;
    quiet_until = 0;
    acc_seen = '0;
    w_vld = '0;
    req_valid = 3'b111;
    #1;
    check_reset_outputs("midtone_reset");
    @(negedge clk);
    check_reset_outputs("held_reset");
    req_valid = '0;
    reset = 1'b1;
    post(1, 4'd11, 3'd1);
    run(30);

    // Drain everything still outstanding.
    run(150);
    check("queue_empty", exp_q.size(), 32'd0);
    check("requests_served", {29'd0, w_vld & ~acc_seen}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piezo_sound_arbiter.md
# piezo_sound_arbiter

Shares the single piezo driver between three tone sources: the miss-sound generator, the key-press echo and the automatic note playback. Each source issues one-tone requests (4-bit note code plus duration in game ticks) over a valid/ready handshake. The arbiter grants by fixed priority, lets higher-priority tones preempt, and times each tone on its own tick divider. It drives `piezo_out` for the game datapath and reports completion or preemption back to each requester.

## Interface
- `TICK_DIV`, 5_000_000, clock cycles per game tick (≥2)
- `GAP_TICKS`, 1, silent ticks inserted after a naturally completed tone (0 = none)
- `DUR_W`, 3, width of duration field
- `clk` input 1 — system clock
- `reset` input 1 — asynchronous, active-low; block held in reset while `reset`==0
- `req_valid` input 3 — per-requester request; bit 0 miss, bit 1 key echo, bit 2 playback
- `req_note` input 3×4 (12) — note code per requester, [4i+3:4i]; 0 = rest
- `req_dur` input 3×DUR_W — duration in ticks per requester; 0 treated as 1
- `stop` input 1 — synchronous abort of active tone/gap
- `req_ready` output 3 — accept strobe; transfer when valid&ready
- `piezo_out` output 4 — note currently sounding, 0 = silent
- `grant` output 3 — one-hot owner of current tone, 0 when none
- `busy` output 1 — state ≠ IDLE
- `done` output 3 — one-cycle pulse: owner's tone completed naturally
- `dropped` output 3 — one-cycle pulse: owner's tone preempted

## Operation
- Reset values: `piezo_out`=0, `grant`=0, `busy`=0, `done`=0, `dropped`=0, state IDLE, divider 0; `req_ready` forced 0 while `reset`==0.
- Priority fixed: miss (0) > echo (1) > playback (2).
- Requester holds valid and payload stable until accepted; arbiter never drops an unaccepted request.
- `req_ready` combinational: at most one bit high, for the highest-priority valid requester eligible this cycle.
- States: IDLE, PLAY, GAP.
- IDLE: any valid accepted → PLAY; latch note, remaining = max(dur,1), `grant` = requester, divider cleared.
- PLAY: divider tick decrements remaining; at remaining==1 on tick → completion: `done[owner]` pulse, `piezo_out`=0, `grant`=0, → GAP (or IDLE if `GAP_TICKS`=0), divider cleared.
- PLAY preemption: valid from a strictly higher-priority requester than owner is accepted same cycle; `dropped[old]` pulse; new tone loaded; no gap; divider cleared.
- Equal or lower priority never preempts; it waits.
- GAP: silent for `GAP_TICKS` ticks, no acceptance (including miss), then IDLE.
- Rest (note 0): accepted and timed normally; `piezo_out`=0, `grant` set.
- `stop`=1: next cycle IDLE, `piezo_out`=0, `grant`=0; no `done`/`dropped`; `req_ready`=0 while `stop` high.

## Timing
- Accept in cycle N → `piezo_out`/`grant` valid from N+1.
- Tone occupies N+1 … N+dur×TICK_DIV exactly; completion cycle N+dur×TICK_DIV+1 shows `done` pulse and `piezo_out`=0.
- GAP occupies GAP_TICKS×TICK_DIV cycles from completion cycle; `req_ready` may rise in the following cycle.
- Preemption accept in cycle M → `dropped` and new note both in M+1.
- Completion and higher-priority valid in same cycle: completion wins (`done`, not `dropped`); request waits through GAP.
- Stop and valid in same cycle: stop wins, no accept.
- Reset mid-tone: immediate silence and reset values, no pulses.

## Structure
- Package `piezo_arb_pkg`: state enum {IDLE, PLAY, GAP}; requester index constants REQ_MISS=0, REQ_ECHO=1, REQ_PLAY=2; NOTE_REST=4'd0.
- Sub-module `tick_gen`: counter 0..TICK_DIV-1 with synchronous `clear`, one-cycle `tick` output; width from `$clog2(TICK_DIV)`.

## Test plan
(TICK_DIV=4, GAP_TICKS=1)
- Reset: assert `reset`=0 mid-tone → `piezo_out`=0, `grant`=0, `busy`=0, `req_ready`=0; release → IDLE.
- Playback note 5, dur 2, accepted cycle 10 → `piezo_out`=5 cycles 11–18, `done`=3'b100 and `piezo_out`=0 at 19, GAP 19–22, `req_ready[2]` possible at 23.
- All three valid in IDLE → only `req_ready`=3'b001; miss note plays; echo, then playback, served afterwards in order, each separated by 4 gap cycles.
- Playback note 3 dur 7 playing; echo note 9 dur 1 valid cycle M → `req_ready[1]` at M; at M+1 `dropped`=3'b100, `piezo_out`=9, `grant`=3'b010.
- `stop` pulse mid-tone → next cycle IDLE, `piezo_out`=0, `done`=`dropped`=0; request valid with `stop` high not accepted.
- dur=0, note 0 → rest of exactly 4 cycles, `grant` set, `piezo_out`=0, `done` pulse afterwards; miss valid during GAP waits until IDLE.
